// File: rtl/symm_orth_ctrl_if.sv
// Strobe/handshake bundle between the FastICA orthogonalization sequencer and its environment.
// Valid/ready usage: mm_start is a one-cycle launch; mm_done is a one-cycle completion pulse, accepted only after the launch cycle.
interface symm_orth_ctrl_if #(
  parameter int ITER_W = 4
);
  logic              start;
  logic              abort;
  logic [ITER_W-1:0] num_iter;
  logic              mm_done;
  logic              mm_start;
  logic              mm_sel;
  logic              en_mul2;
  logic              en_sub;
  logic              w_load;
  logic              busy;
  logic              done;
  logic              err;
  logic [ITER_W-1:0] iter_cnt;
  logic [2:0]        dbg_state;

  modport master (
    output start, abort, num_iter, mm_done,
    input  mm_start, mm_sel, en_mul2, en_sub, w_load, busy, done, err, iter_cnt, dbg_state
  );

  modport slave (
    input  start, abort, num_iter, mm_done,
    output mm_start, mm_sel, en_mul2, en_sub, w_load, busy, done, err, iter_cnt, dbg_state
  );
endinterface

// File: rtl/symm_orth_ctrl.sv
// Sequencer for W <- 1.5*W - 0.5*W*(W^T*W), iterated num_iter times, with a per-multiply watchdog.
// Issues strobes only; every output is registered and derived from the next state.
module symm_orth_ctrl #(
  parameter int ITER_W  = 4,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic           clk_ctrl,
  input  logic           rstn_ctrl,
  symm_orth_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MM1  = 3'd1,
    MM2  = 3'd2,
    SUB  = 3'd3,
    WB   = 3'd4,
    FIN  = 3'd5,
    ERR  = 3'd6
  } state_t;

  localparam logic [TO_W-1:0] LP_TIMEOUT = TO_W'(TIMEOUT);

  state_t            r_state;
  logic [TO_W-1:0]   r_wd;
  logic [ITER_W-1:0] r_iter;
  logic [ITER_W-1:0] r_num;
  logic              r_mm_start;
  logic              r_mm_sel;
  logic              r_en_mul2;
  logic              r_en_sub;
  logic              r_w_load;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  state_t            w_nxt;
  logic [TO_W-1:0]   w_wd_nxt;
  logic [ITER_W-1:0] w_iter_nxt;
  logic [ITER_W-1:0] w_num_nxt;
  logic [ITER_W-1:0] w_iter_inc;
  logic              w_done_ok;
  logic              w_accept;

  // A completion pulse coinciding with the launch cycle belongs to no multiply of ours.
  assign w_done_ok  = bus.mm_done & ~r_mm_start;
  assign w_iter_inc = r_iter + ITER_W'(1);
  assign w_accept   = bus.start & ((r_state == IDLE) | (r_state == ERR));

  always_comb begin
    w_nxt      = r_state;
    w_wd_nxt   = r_wd;
    w_iter_nxt = r_iter;
    w_num_nxt  = r_num;
    if (bus.abort) begin
      w_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE, ERR: begin
          if (w_accept) begin
            w_iter_nxt = '0;
            if (bus.num_iter == '0) begin
              w_nxt = FIN;
            end else begin
              w_nxt     = MM1;
              w_num_nxt = bus.num_iter;
              w_wd_nxt  = '0;
            end
          end
        end
        MM1: begin
          if (w_done_ok) begin
            w_nxt    = MM2;
            w_wd_nxt = '0;
          end else if (r_wd == LP_TIMEOUT) begin
            w_nxt = ERR;
          end else begin
            w_wd_nxt = r_wd + TO_W'(1);
          end
        end
        MM2: begin
          if (w_done_ok) begin
            w_nxt = SUB;
          end else if (r_wd == LP_TIMEOUT) begin
            w_nxt = ERR;
          end else begin
            w_wd_nxt = r_wd + TO_W'(1);
          end
        end
        SUB: w_nxt = WB;
        WB: begin
          w_iter_nxt = w_iter_inc;
          if (w_iter_inc == r_num) begin
            w_nxt = FIN;
          end else begin
            w_nxt    = MM1;
            w_wd_nxt = '0;
          end
        end
        FIN:     w_nxt = IDLE;
        default: w_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_ctrl or negedge rstn_ctrl) begin
    if (!rstn_ctrl) begin
      r_state    <= IDLE;
      r_wd       <= '0;
      r_iter     <= '0;
      r_num      <= '0;
      r_mm_start <= 1'b0;
      r_mm_sel   <= 1'b0;
      r_en_mul2  <= 1'b0;
      r_en_sub   <= 1'b0;
      r_w_load   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_wd       <= w_wd_nxt;
      r_iter     <= w_iter_nxt;
      r_num      <= w_num_nxt;
      // Launch strobes fire only on entry; the scaler runs alongside the second multiply.
      r_mm_start <= ((w_nxt == MM1) & (r_state != MM1)) | ((w_nxt == MM2) & (r_state != MM2));
      r_mm_sel   <= (w_nxt == MM2);
      r_en_mul2  <= (w_nxt == MM2) & (r_state != MM2);
      r_en_sub   <= (w_nxt == SUB);
      r_w_load   <= (w_nxt == WB);
      r_busy     <= (w_nxt == MM1) | (w_nxt == MM2) | (w_nxt == SUB) | (w_nxt == WB);
      r_done     <= (w_nxt == FIN);
      r_err      <= (w_nxt == ERR);
    end
  end

  assign bus.mm_start  = r_mm_start;
  assign bus.mm_sel    = r_mm_sel;
  assign bus.en_mul2   = r_en_mul2;
  assign bus.en_sub    = r_en_sub;
  assign bus.w_load    = r_w_load;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.iter_cnt  = r_iter;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_symm_orth_ctrl.sv
// Directed bench for symm_orth_ctrl: strobe counting monitor, auto-responding multiplier model, scoreboard.
module tb_symm_orth_ctrl;
  localparam int ITER_W  = 4;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 200;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MM1  = 3'd1;
  localparam logic [2:0] S_MM2  = 3'd2;

  logic clk;
  logic rstn;

  symm_orth_ctrl_if #(.ITER_W(ITER_W)) intf ();

  symm_orth_ctrl #(.ITER_W(ITER_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_ctrl  (clk),
    .rstn_ctrl (rstn),
    .bus       (intf.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- multiplier model ----------------
  logic auto_resp = 1'b0;
  int   k_lat     = 3;
  logic auto_done = 1'b0;
  logic man_done  = 1'b0;
  int   cd        = 0;
  assign intf.mm_done = auto_done | man_done;

  always @(posedge clk) begin
    if (!rstn) begin
      cd = 0;
    end else if (intf.mm_start && auto_resp) begin
      cd = k_lat;
    end else if (cd != 0) begin
      cd = cd - 1;
    end
    auto_done <= (cd == 1);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int n_mm_start = 0, n_mul2 = 0, n_sub = 0, n_wload = 0, n_done = 0, n_busy = 0;
  int done_cyc = 0;
  logic [0:0] got_q[$];

  always @(negedge clk) begin
    if (rstn) begin
      if (intf.mm_start) begin
        n_mm_start <= n_mm_start + 1;
        got_q.push_back(intf.mm_sel);
      end
      if (intf.en_mul2) n_mul2 <= n_mul2 + 1;
      if (intf.en_sub)  n_sub  <= n_sub + 1;
      if (intf.w_load)  n_wload <= n_wload + 1;
      if (intf.busy)    n_busy <= n_busy + 1;
      if (intf.done) begin
        n_done   <= n_done + 1;
        done_cyc <= cyc;
      end
      if ((32'(intf.mm_start) + 32'(intf.en_sub) + 32'(intf.w_load) + 32'(intf.done)) > 1)
        check("strobe_onehot", 32'(intf.mm_start + intf.en_sub + intf.w_load + intf.done), 1);
    end
  end

  // ---------------- driver tasks ----------------
  int t0;
  int b_start, b_mul2, b_sub, b_wload, b_done, b_busy, b_q;

  task automatic snap();
    b_start = n_mm_start; b_mul2 = n_mul2; b_sub = n_sub;
    b_wload = n_wload; b_done = n_done; b_busy = n_busy; b_q = got_q.size();
  endtask

  task automatic goto_cycle(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start(input logic [ITER_W-1:0] n);
    t0 = cyc;
    intf.start    = 1'b1;
    intf.num_iter = n;
    @(posedge clk); #1;
    intf.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c;
    c = 0;
    while ((n_done == b_done) && (c < budget)) begin
      @(posedge clk); #1;
      c++;
    end
    check(tag, 32'(n_done - b_done), 1);
  endtask

  logic [0:0] exp_q[$];

  initial begin
    #300000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "simulation time limit");
  end

  initial begin
    rstn = 1'b0;
    intf.start = 1'b0;
    intf.abort = 1'b0;
    intf.num_iter = '0;
    #23 rstn = 1'b1;
    @(posedge clk); #1;

    // reset state
    @(negedge clk);
    check("rst_mm_start", 32'(intf.mm_start), 0);
    check("rst_busy", 32'(intf.busy), 0);
    check("rst_done", 32'(intf.done), 0);
    check("rst_err", 32'(intf.err), 0);
    check("rst_iter", 32'(intf.iter_cnt), 0);
    check("rst_state", 32'(intf.dbg_state), 32'(S_IDLE));
    @(posedge clk); #1;

    // two iterations, multiplier answers 3 cycles after each launch
    auto_resp = 1'b1; k_lat = 3;
    snap();
    pulse_start(4'd2);
    intf.num_iter = 4'($urandom_range(3, 15));
    wait_done("t2_done_seen", 100);
    @(negedge clk);
    check("t2_nstart", 32'(n_mm_start - b_start), 4);
    check("t2_nmul2", 32'(n_mul2 - b_mul2), 2);
    check("t2_nsub", 32'(n_sub - b_sub), 2);
    check("t2_nwload", 32'(n_wload - b_wload), 2);
    check("t2_done_cyc", 32'(done_cyc - t0), 21);
    check("t2_iter", 32'(intf.iter_cnt), 2);
    check("t2_busy", 32'(intf.busy), 0);
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++)
      if (b_q + i < got_q.size()) check("t2_sel", 32'(got_q[b_q + i]), 32'(exp_q[i]));
    @(posedge clk); #1;

    // zero iterations: immediate done, no strobes
    snap();
    pulse_start(4'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("t3_ndone", 32'(n_done - b_done), 1);
    check("t3_done_cyc", 32'(done_cyc - t0), 1);
    check("t3_nstart", 32'(n_mm_start - b_start), 0);
    check("t3_nmul2", 32'(n_mul2 - b_mul2), 0);
    check("t3_nwload", 32'(n_wload - b_wload), 0);
    check("t3_nbusy", 32'(n_busy - b_busy), 0);

    // watchdog: no response after the first launch
    auto_resp = 1'b0;
    snap();
    pulse_start(4'd1);
    goto_cycle(t0 + TIMEOUT + 1);
    @(negedge clk);
    check("t4_err_before", 32'(intf.err), 0);
    check("t4_busy_before", 32'(intf.busy), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t4_err", 32'(intf.err), 1);
    check("t4_busy", 32'(intf.busy), 0);
    check("t4_iter", 32'(intf.iter_cnt), 0);
    repeat (4) begin @(posedge clk); #1; end
    check("t4_err_sticky", 32'(intf.err), 1);
    check("t4_nstart", 32'(n_mm_start - b_start), 1);
    auto_resp = 1'b1; k_lat = 2;
    snap();
    pulse_start(4'd1);
    @(negedge clk);
    check("t4_err_clr", 32'(intf.err), 0);
    check("t4_busy_rerun", 32'(intf.busy), 1);
    wait_done("t4_done_seen", 50);
    check("t4_done_cyc", 32'(done_cyc - t0), 9);
    check("t4_iter_rerun", 32'(intf.iter_cnt), 1);
    @(posedge clk); #1;

    // abort together with start while in MM2
    snap();
    pulse_start(4'd1);
    goto_cycle(t0 + 4);
    intf.abort = 1'b1;
    intf.start = 1'b1;
    @(negedge clk);
    check("t5_in_mm2", 32'(intf.dbg_state), 32'(S_MM2));
    @(posedge clk); #1;
    intf.abort = 1'b0;
    intf.start = 1'b0;
    @(negedge clk);
    check("t5_state", 32'(intf.dbg_state), 32'(S_IDLE));
    check("t5_busy", 32'(intf.busy), 0);
    check("t5_mm_start", 32'(intf.mm_start), 0);
    check("t5_mm_sel", 32'(intf.mm_sel), 0);
    repeat (8) begin @(posedge clk); #1; end
    check("t5_nsub", 32'(n_sub - b_sub), 0);
    check("t5_nwload", 32'(n_wload - b_wload), 0);
    check("t5_ndone", 32'(n_done - b_done), 0);
    check("t5_state_late", 32'(intf.dbg_state), 32'(S_IDLE));

    // stray done in IDLE, and done coinciding with the launch cycle
    auto_resp = 1'b0;
    man_done = 1'b1;
    @(posedge clk); #1;
    man_done = 1'b0;
    @(negedge clk);
    check("t6_idle_stray", 32'(intf.dbg_state), 32'(S_IDLE));
    check("t6_idle_busy", 32'(intf.busy), 0);
    @(posedge clk); #1;
    snap();
    pulse_start(4'd1);
    man_done = 1'b1;
    @(negedge clk);
    check("t6_launch", 32'(intf.mm_start), 1);
    @(posedge clk); #1;
    man_done = 1'b0;
    @(negedge clk);
    check("t6_hold_mm1", 32'(intf.dbg_state), 32'(S_MM1));
    goto_cycle(t0 + 4);
    man_done = 1'b1;
    @(posedge clk); #1;
    man_done = 1'b0;
    auto_resp = 1'b1; k_lat = 2;
    @(negedge clk);
    check("t6_mm2", 32'(intf.dbg_state), 32'(S_MM2));
    check("t6_sel", 32'(intf.mm_sel), 1);
    wait_done("t6_done_seen", 50);
    check("t6_done_cyc", 32'(done_cyc - t0), 10);
    check("t6_iter", 32'(intf.iter_cnt), 1);
    @(posedge clk); #1;

    // asynchronous reset during SUB, then a clean single iteration
    k_lat = 1;
    pulse_start(4'd1);
    goto_cycle(t0 + 5);
    #2 rstn = 1'b0;
    #1;
    check("t7_en_sub", 32'(intf.en_sub), 0);
    check("t7_busy", 32'(intf.busy), 0);
    check("t7_iter", 32'(intf.iter_cnt), 0);
    check("t7_state", 32'(intf.dbg_state), 32'(S_IDLE));
    #2 rstn = 1'b1;
    @(posedge clk); #1;
    snap();
    pulse_start(4'd1);
    wait_done("t7_done_seen", 50);
    check("t7_done_cyc", 32'(done_cyc - t0), 7);
    check("t7_nwload", 32'(n_wload - b_wload), 1);
    check("t7_iter_end", 32'(intf.iter_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
